elevator_scheduler: RTL
=======================

# elevator_scheduler

Sequencing controller for the 4-floor elevator car. It latches floor calls from the request keys and tracks the car position from the one-hot floor sensors. It picks the next stop with a direction-preserving (SCAN) policy and drives the motor up/down commands and the door-open timer. It sits between the board inputs (keys, floor switches, door sensor) and the motor/door/HEX outputs, replacing the free-running up/down/complete comparison logic.

## Interface
- FLOORS, 4: number of floors; internal floor index 0..FLOORS-1, displayed as 1..FLOORS.
- DOOR_TICKS, 8: clock cycles the door stays open.
- CLOSE_TICKS, 4: clock cycles spent in door-closing before the car may move.
- clk  in  1: single system clock.
- rst  in  1: reset, synchronous, active-high.
- req  in  FLOORS: floor call per floor, active-high level; a high sample sets the pending bit.
- floor_sensor  in  FLOORS: one-hot car position. All-zero means between floors. More than one bit set is a fault.
- door_obstruct  in  1: door sensor, high while the doorway is blocked.
- motor_up  out  1: drive car upward.
- motor_down  out  1: drive car downward.
- door_open  out  1: door commanded open.
- cur_floor  out  2: last valid floor index.
- pending  out  FLOORS: latched outstanding calls.
- arrive  out  1: one-cycle pulse when the car stops at a called floor.
- fault  out  1: sticky sensor fault.
- hex  out  7: active-low 7-segment digit showing cur_floor+1.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_CLOSE, FAULT. Moore outputs decoded from the registered state.
  - motor_up is high only in MOVE_UP.
  - motor_down is high only in MOVE_DOWN.
  - door_open is high in DOOR_OPEN.
- Position: on a one-hot floor_sensor, cur_floor takes the index of the set bit. All-zero holds cur_floor. Multi-hot in any state goes to FAULT.
- pending update: pending <= (pending | req) & ~clear_mask. clear_mask is the current-floor bit when entering or staying in DOOR_OPEN. A set and a clear of the same bit in the same cycle resolve to clear.
- Direction register dir (up=1), reset to 1.
- IDLE, evaluated in priority order:
  1. If pending[cur_floor] is set, go to DOOR_OPEN.
  2. Else if there are calls above and (dir=1 or no calls below), go to MOVE_UP with dir=1.
  3. Else if there are calls below, go to MOVE_DOWN with dir=0.
  4. Else stay in IDLE.
- MOVE_UP / MOVE_DOWN, on a valid sensor reading:
  - If pending[new floor] is set, go to DOOR_OPEN and pulse arrive.
  - If the top (bottom) floor is reached with no call there, go to IDLE.
- DOOR_OPEN: the timer loads DOOR_TICKS-1 on entry and counts down. A call for cur_floor while open reloads the timer. At 0, go to DOOR_CLOSE.
- DOOR_CLOSE: counts CLOSE_TICKS, then goes to IDLE.
- FAULT: motors off, door_open=0, requests still latched. Only rst exits.

## Timing
- Reset values: state=IDLE, dir=1, cur_floor=0, pending=0, timers=0. All outputs 0 except hex, which shows "1".
- Request sampled at edge N: pending bit visible after N. The state leaves IDLE at edge N+1, so motor or door_open is high from cycle N+2.
- Sensor edge at floor F with a call pending: DOOR_OPEN and the arrive pulse both appear the cycle after the sensor sample. The motor drops in that same cycle.
- Door open for exactly DOOR_TICKS cycles without reopen. The car cannot move sooner than DOOR_TICKS+CLOSE_TICKS cycles after arrival.
- Reset mid-move: the next cycle is IDLE with motors off and pending cleared. cur_floor returns to 0 until the next valid sensor reading.
- Timer width: $clog2(max(DOOR_TICKS,CLOSE_TICKS)+1) bits, unsigned, no wrap.

## Configuration
- DOOR_REOPEN_EN defined: door_obstruct high in DOOR_CLOSE goes back to DOOR_OPEN with the timer reloaded. door_obstruct high in DOOR_OPEN holds the timer at DOOR_TICKS-1.
- DOOR_REOPEN_EN undefined: door_obstruct is ignored and the door closes on timer only.

## Structure
- Shared package elevator_pkg: state enum, FLOORS default, floor index type, segment constants for digits 1–4.
- One sub-module: floor_hex (combinational cur_floor to active-low 7-segment), reusable by the board top.

## Test plan
- Reset, floor_sensor=0001, req=1000 for 1 cycle → motor_up from cycle 2. Step sensor 0010, 0100, 1000 → stop at floor 3, arrive pulse, door_open 8 cycles, pending=0000.
- Car at floor 0 moving up, pending=1100; while between floors raise req[1] before sensor 0010 → stops at 1, then 2, then 3 in order, never asserting motor_down.
- Car at floor 2 idle, req=0100 → door_open with no motor activity, bit cleared. A repeated req[2] while open reloads the timer (door open 8 cycles after the last request).
- DOOR_REOPEN_EN defined: door_obstruct pulse during DOOR_CLOSE → back to DOOR_OPEN with a full 8-cycle reopen. Undefined: no effect.
- floor_sensor=0110 during MOVE_UP → fault=1, motors 0 next cycle; stays latched until rst.
- rst asserted during MOVE_DOWN with pending=0001 → next cycle all outputs at reset values, pending=0000.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and helpers for the 4-floor elevator controller.
//   - FLOORS / FLOOR_W : floor count and floor index width
//   - floor_t          : floor index type (0..FLOORS-1, displayed as 1..FLOORS)
//   - state_t          : scheduler FSM state encoding
//   - SEG_*            : active-low 7-segment patterns {g,f,e,d,c,b,a} for digits 1-4
//   - helper functions : sensor decode and floor masks
package elevator_pkg;

   localparam int FLOORS  = 4;
   localparam int FLOOR_W = $clog2(FLOORS);

   typedef logic [FLOOR_W-1:0] floor_t;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_MOVE_UP    = 3'd1,
      S_MOVE_DOWN  = 3'd2,
      S_DOOR_OPEN  = 3'd3,
      S_DOOR_CLOSE = 3'd4,
      S_FAULT      = 3'd5
   } state_t;

   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // More than one floor switch closed at once cannot happen physically.
   function automatic logic multi_hot(input logic [FLOORS-1:0] v);
      return (v & (v - {{(FLOORS-1){1'b0}}, 1'b1})) != {FLOORS{1'b0}};
   endfunction

   // Index of the set bit of a one-hot vector (0 when all-zero).
   function automatic floor_t onehot_index(input logic [FLOORS-1:0] v);
      floor_t idx;
      idx = floor_t'(0);
      for (int i = 0; i < FLOORS; i++) begin
         if (v[i]) idx = floor_t'(i);
         else      idx = idx;
      end
      return idx;
   endfunction

   function automatic logic [FLOORS-1:0] floor_bit(input floor_t f);
      return {{(FLOORS-1){1'b0}}, 1'b1} << f;
   endfunction

   // Floors strictly above f.
   function automatic logic [FLOORS-1:0] above_mask(input floor_t f);
      logic [FLOORS-1:0] m;
      for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
      return m;
   endfunction

   // Floors strictly below f.
   function automatic logic [FLOORS-1:0] below_mask(input floor_t f);
      logic [FLOORS-1:0] m;
      for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
      return m;
   endfunction

endpackage

// File: rtl/floor_hex.sv
// floor_hex: combinational floor index to active-low 7-segment digit (index+1).
//   floor_idx in  FLOOR_W : floor index 0..FLOORS-1
//   seg       out 7       : active-low segments {g,f,e,d,c,b,a}
module floor_hex
   import elevator_pkg::*;
(
   input  logic [FLOOR_W-1:0] floor_idx,
   output logic [6:0]         seg
);

   // Digit lookup; out-of-range indices blank the display.
   always_comb begin
      seg = SEG_BLANK;
      case (floor_idx)
         2'd0:    seg = SEG_1;
         2'd1:    seg = SEG_2;
         2'd2:    seg = SEG_3;
         2'd3:    seg = SEG_4;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-policy sequencing controller for a 4-floor car.
// Latches floor calls, tracks the car from one-hot floor switches, drives the
// motor up/down commands and the door-open/close timers.
//   clk, rst (sync, active-high)
//   req[FLOORS]           in  : floor calls (level, latched into pending)
//   floor_sensor[FLOORS]  in  : one-hot car position, 0 = between floors
//   door_obstruct         in  : doorway blocked
//   motor_up/motor_down   out : motor commands
//   door_open             out : door commanded open
//   cur_floor[FLOOR_W]    out : last valid floor index
//   pending[FLOORS]       out : outstanding calls
//   arrive                out : one-cycle pulse on stopping at a called floor
//   fault                 out : sticky multi-hot sensor fault (rst only exit)
//   hex[7]                out : active-low digit cur_floor+1
// Optional feature macro DOOR_REOPEN_EN: obstruction holds the open timer and
// reopens a closing door; without it door_obstruct is ignored.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int DOOR_TICKS  = 8,
   parameter int CLOSE_TICKS = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [FLOORS-1:0]  req,
   input  logic [FLOORS-1:0]  floor_sensor,
   input  logic               door_obstruct,
   output logic               motor_up,
   output logic               motor_down,
   output logic               door_open,
   output logic [FLOOR_W-1:0] cur_floor,
   output logic [FLOORS-1:0]  pending,
   output logic               arrive,
   output logic               fault,
   output logic [6:0]         hex
);

   localparam int TIMER_MAX = (DOOR_TICKS > CLOSE_TICKS) ? DOOR_TICKS : CLOSE_TICKS;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
   localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_TICKS - 1);
   localparam logic [TIMER_W-1:0] CLOSE_LOAD = TIMER_W'(CLOSE_TICKS - 1);
   localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
   localparam floor_t TOP_FLOOR    = floor_t'(FLOORS - 1);
   localparam floor_t BOTTOM_FLOOR = floor_t'(0);

`ifdef DOOR_REOPEN_EN
   localparam logic REOPEN_EN = 1'b1;
`else
   localparam logic REOPEN_EN = 1'b0;
`endif

   state_t              state, state_next;
   logic                dir, dir_next;
   logic [TIMER_W-1:0]  timer, timer_next;
   logic                arrive_next;
   logic                sensor_multi, sensor_valid;
   floor_t              floor_next, door_floor;
   logic                calls_above, calls_below;
   logic [FLOORS-1:0]   clear_mask;
   logic                obstructed;

   assign obstructed = door_obstruct && REOPEN_EN;

   // Sensor decode: new position on a clean one-hot reading, else hold.
   always_comb begin
      sensor_multi = multi_hot(floor_sensor);
      sensor_valid = (floor_sensor != {FLOORS{1'b0}}) && !sensor_multi;
      if (sensor_valid) floor_next = onehot_index(floor_sensor);
      else              floor_next = cur_floor;
   end

   // State, direction, timer, position and call latch registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         dir       <= 1'b1;
         timer     <= TIMER_ZERO;
         cur_floor <= floor_t'(0);
         pending   <= {FLOORS{1'b0}};
         arrive    <= 1'b0;
      end else begin
         state     <= state_next;
         dir       <= dir_next;
         timer     <= timer_next;
         cur_floor <= floor_next;
         pending   <= (pending | req) & ~clear_mask;   // clear wins over a same-cycle set
         arrive    <= arrive_next;
      end
   end

   // Next-state logic: SCAN scheduling, door timers, fault capture.
   always_comb begin
      state_next  = state;
      dir_next    = dir;
      timer_next  = timer;
      arrive_next = 1'b0;
      calls_above = |(pending & above_mask(cur_floor));
      calls_below = |(pending & below_mask(cur_floor));
      if (sensor_multi) begin
         state_next = S_FAULT;
         timer_next = TIMER_ZERO;
      end else begin
         case (state)
            S_IDLE: begin
               if (pending[cur_floor]) begin
                  state_next = S_DOOR_OPEN;
                  timer_next = DOOR_LOAD;
               end else if (calls_above && (dir || !calls_below)) begin
                  state_next = S_MOVE_UP;
                  dir_next   = 1'b1;
               end else if (calls_below) begin
                  state_next = S_MOVE_DOWN;
                  dir_next   = 1'b0;
               end else begin
                  state_next = S_IDLE;
               end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
               if (sensor_valid && pending[floor_next]) begin
                  state_next  = S_DOOR_OPEN;
                  timer_next  = DOOR_LOAD;
                  arrive_next = 1'b1;
               end else if (sensor_valid && (state == S_MOVE_UP) && (floor_next == TOP_FLOOR)) begin
                  state_next = S_IDLE;
               end else if (sensor_valid && (state == S_MOVE_DOWN) && (floor_next == BOTTOM_FLOOR)) begin
                  state_next = S_IDLE;
               end else begin
                  state_next = state;
               end
            end
            S_DOOR_OPEN: begin
               // A new call for this floor or a blocked doorway restarts the hold time.
               if (obstructed || req[cur_floor]) begin
                  timer_next = DOOR_LOAD;
               end else if (timer == TIMER_ZERO) begin
                  state_next = S_DOOR_CLOSE;
                  timer_next = CLOSE_LOAD;
               end else begin
                  timer_next = timer - TIMER_ONE;
               end
            end
            S_DOOR_CLOSE: begin
               if (obstructed) begin
                  state_next = S_DOOR_OPEN;
                  timer_next = DOOR_LOAD;
               end else if (timer == TIMER_ZERO) begin
                  state_next = S_IDLE;
                  timer_next = TIMER_ZERO;
               end else begin
                  timer_next = timer - TIMER_ONE;
               end
            end
            S_FAULT: begin
               state_next = S_FAULT;
               timer_next = TIMER_ZERO;
            end
            default: begin
               state_next = S_FAULT;
               timer_next = TIMER_ZERO;
            end
         endcase
      end
      // When arriving from a move, the floor being served is the one just sensed.
      if ((state == S_MOVE_UP) || (state == S_MOVE_DOWN)) door_floor = floor_next;
      else                                                door_floor = cur_floor;
      if (state_next == S_DOOR_OPEN) clear_mask = floor_bit(door_floor);
      else                           clear_mask = {FLOORS{1'b0}};
   end

   // Moore output decode from the registered state.
   always_comb begin
      motor_up   = 1'b0;
      motor_down = 1'b0;
      door_open  = 1'b0;
      fault      = 1'b0;
      case (state)
         S_MOVE_UP:   motor_up   = 1'b1;
         S_MOVE_DOWN: motor_down = 1'b1;
         S_DOOR_OPEN: door_open  = 1'b1;
         S_FAULT:     fault      = 1'b1;
         default: begin
            motor_up   = 1'b0;
            motor_down = 1'b0;
            door_open  = 1'b0;
            fault      = 1'b0;
         end
      endcase
   end

   floor_hex u_floor_hex (
      .floor_idx (cur_floor),
      .seg       (hex)
   );

endmodule
